// File: rtl/apb_fabric_pkg.sv
// ---------------------------------------------------------------------------
// apb_fabric_pkg
// Shared types and constants for the APB I/O fabric.
//   apb_fabric_state_e : transfer sequencing states (IDLE/SETUP/ACCESS/ERR)
//   apb_err_cause_e    : cause codes logged for software
//   APB_DATA_W / APB_ADDR_W : bus widths
//   sat_inc8           : saturating 8-bit increment used by the error counter
// ---------------------------------------------------------------------------
package apb_fabric_pkg;

    localparam int APB_DATA_W = 8;
    localparam int APB_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } apb_fabric_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_UNMAPPED    = 2'd1,
        CAUSE_QUARANTINED = 2'd2,
        CAUSE_TIMEOUT     = 2'd3
    } apb_err_cause_e;

    // The error counter sticks at its maximum instead of wrapping so that
    // software never mistakes a flood of errors for a quiet bus.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ---------------------------------------------------------------------------
// apb_timeout_counter
// Counts stalled ACCESS cycles of the currently selected slave and flags the
// cycle in which the stall budget runs out.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : restart the count (asserted in the SETUP cycle)
//   i_count   : this cycle is a stalled access cycle
//   o_expire  : this stalled cycle is the last one allowed
// ---------------------------------------------------------------------------
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // The count holds the number of stalled cycles already seen, so the
    // budget is spent when a further stall arrives with the count one short.
    assign o_expire = i_count && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count stalled cycles; a fresh transfer always starts from zero and the
    // count freezes at expiry because the fabric leaves ACCESS right after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && !o_expire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_io_fabric.sv
// ---------------------------------------------------------------------------
// apb_io_fabric
// APB fabric between the upstream master and SLAVE_CNT I/O peripherals.
// Decodes up_paddr[SEL_MSB:SEL_LSB] to a one-hot slave select, routes the
// selected slave's response back, terminates unmapped accesses with an error
// and keeps a small error log (count, address, cause) with an irq.
// Optional feature macro: APB_FABRIC_TIMEOUT_EN adds a stall timeout and a
// per-slave quarantine mask (causes 2 and 3); without it ACCESS waits forever.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   up_p*                          : upstream APB slave port
//   s_paddr/s_pwdata/s_pwrite      : shared downstream request (pass-through)
//   s_psel/s_penable               : one-hot select, shared enable
//   s_prdata/s_pready              : per-slave response (slave i at [8i+7:8i])
//   err_clr                        : pulse clearing log and quarantine
//   err_cnt/err_addr/err_cause/irq : error log for software
// ---------------------------------------------------------------------------
module apb_io_fabric
    import apb_fabric_pkg::*;
#(
    parameter int                    SLAVE_CNT      = 4,
    parameter int                    SEL_MSB        = 15,
    parameter int                    SEL_LSB        = 8,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [APB_DATA_W-1:0] DEFAULT_RDATA  = 8'hFF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [APB_ADDR_W-1:0]           up_paddr,
    input  logic [APB_DATA_W-1:0]           up_pwdata,
    input  logic                            up_pwrite,
    input  logic                            up_psel,
    input  logic                            up_penable,
    output logic [APB_DATA_W-1:0]           up_prdata,
    output logic                            up_pready,
    output logic                            up_pslverr,
    output logic [APB_ADDR_W-1:0]           s_paddr,
    output logic [APB_DATA_W-1:0]           s_pwdata,
    output logic                            s_pwrite,
    output logic [SLAVE_CNT-1:0]            s_psel,
    output logic                            s_penable,
    input  logic [SLAVE_CNT*APB_DATA_W-1:0] s_prdata,
    input  logic [SLAVE_CNT-1:0]            s_pready,
    input  logic                            err_clr,
    output logic [7:0]                      err_cnt,
    output logic [APB_ADDR_W-1:0]           err_addr,
    output logic [1:0]                      err_cause,
    output logic                            irq
);

    localparam int               SEL_W       = SEL_MSB - SEL_LSB + 1;
    localparam logic [SEL_W:0]   SLAVE_LIMIT = (SEL_W + 1)'(SLAVE_CNT);

    apb_fabric_state_e       r_state;
    apb_fabric_state_e       w_next;
    apb_err_cause_e          r_pend_cause;
    logic [SEL_W-1:0]        w_idx;
    logic                    w_mapped;
    logic [SEL_W-1:0]        r_cur_idx;
    logic                    r_mapped;
    logic [APB_ADDR_W-1:0]   r_addr;
    logic [SLAVE_CNT-1:0]    w_sel_onehot;
    logic                    w_sel_ready;
    logic [APB_DATA_W-1:0]   w_sel_rdata;
    logic                    w_sel_quar;
    logic [SLAVE_CNT-1:0]    w_quar;
    logic                    w_expire;
    logic                    w_start;
    logic [7:0]              r_err_cnt;
    logic [APB_ADDR_W-1:0]   r_err_addr;
    apb_err_cause_e          r_err_cause;

    assign s_paddr  = up_paddr;
    assign s_pwdata = up_pwdata;
    assign s_pwrite = up_pwrite;

    // The page field is zero-extended by one bit before the compare so that
    // SLAVE_CNT equal to the full field range still fits.
    assign w_idx    = up_paddr[SEL_MSB:SEL_LSB];
    assign w_mapped = ({1'b0, w_idx} < SLAVE_LIMIT);
    assign w_start  = (r_state == ST_IDLE) && up_psel && !up_penable;

    // Capture the transfer's target and address when the master opens a
    // transfer; everything downstream works from these latched copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_idx <= '0;
            r_mapped  <= 1'b0;
            r_addr    <= '0;
        end else if (w_start) begin
            r_cur_idx <= w_idx;
            r_mapped  <= w_mapped;
            r_addr    <= up_paddr;
        end
    end

    // Select the latched slave's response lines. An unmapped index matches
    // nothing, which leaves the one-hot select empty.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_ready  = 1'b0;
        w_sel_rdata  = '0;
        w_sel_quar   = 1'b0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            if (r_cur_idx == SEL_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_ready     = s_pready[i];
                w_sel_rdata     = s_prdata[i*APB_DATA_W +: APB_DATA_W];
                w_sel_quar      = w_quar[i];
            end
        end
    end

`ifdef APB_FABRIC_TIMEOUT_EN
    logic                 w_to_count;
    logic [SLAVE_CNT-1:0] r_quar;

    assign w_to_count = (r_state == ST_ACCESS) && !w_sel_ready;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_load   (r_state == ST_SETUP),
        .i_count  (w_to_count),
        .o_expire (w_expire)
    );

    // A slave that timed out is fenced off until software clears the log.
    // When a clear lands on a timeout ERR cycle only the new bit survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quar <= '0;
        end else if ((r_state == ST_ERR) && (r_pend_cause == CAUSE_TIMEOUT)) begin
            r_quar <= (err_clr ? '0 : r_quar) | w_sel_onehot;
        end else if (err_clr) begin
            r_quar <= '0;
        end
    end

    assign w_quar = r_quar;
`else
    assign w_expire = 1'b0;
    assign w_quar   = '0;
`endif

    // Decide the cause of the upcoming ERR cycle on the way into it, so the
    // ERR cycle itself only has to copy it into the log.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_cause <= CAUSE_NONE;
        end else if (r_state == ST_SETUP) begin
            if (!r_mapped) begin
                r_pend_cause <= CAUSE_UNMAPPED;
            end else if (w_sel_quar) begin
                r_pend_cause <= CAUSE_QUARANTINED;
            end else begin
                r_pend_cause <= CAUSE_NONE;
            end
        end else if ((r_state == ST_ACCESS) && w_expire) begin
            r_pend_cause <= CAUSE_TIMEOUT;
        end
    end

    // State register for the transfer sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and bus outputs. SETUP drives the downstream setup phase,
    // ACCESS passes the selected slave's response straight through, and ERR
    // completes the transfer locally. Reset forces the handshake outputs low
    // even before the state register has been cleared.
    always_comb begin
        w_next     = r_state;
        s_psel     = '0;
        s_penable  = 1'b0;
        up_pready  = 1'b0;
        up_pslverr = 1'b0;
        up_prdata  = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (up_psel && !up_penable) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_mapped && !w_sel_quar) begin
                    s_psel = w_sel_onehot;
                    w_next = ST_ACCESS;
                end else begin
                    w_next = ST_ERR;
                end
            end
            ST_ACCESS: begin
                s_psel    = w_sel_onehot;
                s_penable = 1'b1;
                up_pready = w_sel_ready;
                up_prdata = w_sel_rdata;
                if (w_sel_ready) begin
                    w_next = ST_IDLE;
                end else if (w_expire) begin
                    w_next = ST_ERR;
                end
            end
            ST_ERR: begin
                up_pready  = 1'b1;
                up_pslverr = 1'b1;
                up_prdata  = DEFAULT_RDATA;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            s_psel     = '0;
            s_penable  = 1'b0;
            up_pready  = 1'b0;
            up_pslverr = 1'b0;
        end
    end

    // Error log: every ERR cycle records one entry. A clear arriving in the
    // same cycle loses to the new entry, leaving a count of exactly one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt   <= '0;
            r_err_addr  <= '0;
            r_err_cause <= CAUSE_NONE;
        end else if (r_state == ST_ERR) begin
            r_err_cnt   <= err_clr ? 8'd1 : sat_inc8(r_err_cnt);
            r_err_addr  <= r_addr;
            r_err_cause <= r_pend_cause;
        end else if (err_clr) begin
            r_err_cnt   <= '0;
            r_err_addr  <= '0;
            r_err_cause <= CAUSE_NONE;
        end
    end

    assign err_cnt   = r_err_cnt;
    assign err_addr  = r_err_addr;
    assign err_cause = r_err_cause;
    assign irq       = (r_err_cnt != 8'd0);

endmodule

// File: tb/tb_apb_io_fabric.sv
// ---------------------------------------------------------------------------
// tb_apb_io_fabric
// Self-checking bench for apb_io_fabric with four slaves. Responds for the
// slaves with programmable wait counts and read data, predicts every transfer
// from the fabric's rules (latency, data, error log, quarantine) and checks.
// The timeout/quarantine section is built only with APB_FABRIC_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_apb_io_fabric;

    localparam int         SLAVE_CNT = 4;
    localparam int         TIMEOUT   = 4;
    localparam logic [7:0] DEF_RDATA = 8'hFF;
`ifdef APB_FABRIC_TIMEOUT_EN
    localparam bit         TO_EN     = 1'b1;
`else
    localparam bit         TO_EN     = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [15:0]              up_paddr;
    logic [7:0]               up_pwdata;
    logic                     up_pwrite;
    logic                     up_psel;
    logic                     up_penable;
    logic [7:0]               up_prdata;
    logic                     up_pready;
    logic                     up_pslverr;
    logic [15:0]              s_paddr;
    logic [7:0]               s_pwdata;
    logic                     s_pwrite;
    logic [SLAVE_CNT-1:0]     s_psel;
    logic                     s_penable;
    logic [SLAVE_CNT*8-1:0]   s_prdata;
    logic [SLAVE_CNT-1:0]     s_pready;
    logic                     err_clr;
    logic [7:0]               err_cnt;
    logic [15:0]              err_addr;
    logic [1:0]               err_cause;
    logic                     irq;

    logic [7:0] slaveData [SLAVE_CNT];
    int         slaveWait [SLAVE_CNT];
    int         accCnt    [SLAVE_CNT] = '{default: 0};

    int          mCnt;
    logic [15:0] mAddr;
    int          mCause;
    bit          mQuar [SLAVE_CNT];

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    apb_io_fabric #(
        .SLAVE_CNT      (SLAVE_CNT),
        .SEL_MSB        (15),
        .SEL_LSB        (8),
        .TIMEOUT_CYCLES (TIMEOUT),
        .DEFAULT_RDATA  (DEF_RDATA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_paddr   (up_paddr),
        .up_pwdata  (up_pwdata),
        .up_pwrite  (up_pwrite),
        .up_psel    (up_psel),
        .up_penable (up_penable),
        .up_prdata  (up_prdata),
        .up_pready  (up_pready),
        .up_pslverr (up_pslverr),
        .s_paddr    (s_paddr),
        .s_pwdata   (s_pwdata),
        .s_pwrite   (s_pwrite),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_prdata   (s_prdata),
        .s_pready   (s_pready),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt),
        .err_addr   (err_addr),
        .err_cause  (err_cause),
        .irq        (irq)
    );

    // Each slave counts how many access cycles it has been enabled and raises
    // pready once its configured number of wait states has passed.
    always @(posedge clk) begin
        for (int i = 0; i < SLAVE_CNT; i++) begin
            if (s_psel[i] && s_penable) accCnt[i] <= accCnt[i] + 1;
            else                        accCnt[i] <= 0;
        end
    end

    always_comb begin
        s_pready = '0;
        s_prdata = '0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            s_pready[i]       = (accCnt[i] >= slaveWait[i]);
            s_prdata[i*8 +: 8] = slaveData[i];
        end
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed no end, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, "_err_cnt"},   32'(err_cnt),   32'(mCnt));
        checkOutput({tag, "_err_addr"},  32'(err_addr),  32'(mAddr));
        checkOutput({tag, "_err_cause"}, 32'(err_cause), 32'(mCause));
        checkOutput({tag, "_irq"},       32'(irq),       32'(mCnt != 0));
    endtask

    task automatic modelClear();
        mCnt   = 0;
        mAddr  = '0;
        mCause = 0;
        for (int i = 0; i < SLAVE_CNT; i++) mQuar[i] = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        modelClear();
        checkLog("clear");
    endtask

    // One complete upstream transfer: predict the outcome, drive the APB
    // master phases, check every fabric cycle and the resulting log.
    task automatic applyStimulus(input string tag, input logic [15:0] addr, input bit wr,
                                 input logic [7:0] wdata, input bit clrAtEnd);
        int         idx;
        int         lat;
        int         cause;
        bit         isErr;
        bit         selOk;
        bit         done;
        logic [3:0] onehot;
        logic [7:0] expData;
        logic [3:0] expPsel;

        idx     = int'(addr[15:8]);
        isErr   = 1'b0;
        selOk   = 1'b0;
        cause   = 0;
        lat     = 1;
        onehot  = 4'b0000;
        expData = DEF_RDATA;
        if (idx >= SLAVE_CNT) begin
            isErr = 1'b1;
            cause = 1;
        end else if (TO_EN && mQuar[idx]) begin
            isErr = 1'b1;
            cause = 2;
        end else begin
            selOk  = 1'b1;
            onehot = 4'b0001 << idx;
            if (TO_EN && slaveWait[idx] >= TIMEOUT) begin
                isErr = 1'b1;
                cause = 3;
                lat   = TIMEOUT + 1;
            end else begin
                lat     = slaveWait[idx] + 1;
                expData = slaveData[idx];
            end
        end

        @(negedge clk);
        up_psel    = 1'b1;
        up_penable = 1'b0;
        up_paddr   = addr;
        up_pwrite  = wr;
        up_pwdata  = wdata;

        @(negedge clk);
        checkOutput({tag, "_t0_psel"},    32'(s_psel),    32'(selOk ? onehot : 4'b0000));
        checkOutput({tag, "_t0_penable"}, 32'(s_penable), 32'd0);
        checkOutput({tag, "_t0_pready"},  32'(up_pready), 32'd0);
        checkOutput({tag, "_paddr"},      32'(s_paddr),   32'(addr));
        checkOutput({tag, "_pwdata"},     32'(s_pwdata),  32'(wdata));
        checkOutput({tag, "_pwrite"},     32'(s_pwrite),  32'(wr));
        up_penable = 1'b1;

        done = 1'b0;
        for (int n = 1; n <= lat + 2 && !done; n++) begin
            @(negedge clk);
            if (n <= lat) begin
                expPsel = (selOk && !(isErr && n == lat)) ? onehot : 4'b0000;
                checkOutput({tag, "_psel"}, 32'(s_psel), 32'(expPsel));
            end
            if (up_pready) begin
                done = 1'b1;
                checkOutput({tag, "_latency"}, 32'(n),          32'(lat));
                checkOutput({tag, "_prdata"},  32'(up_prdata),  32'(expData));
                checkOutput({tag, "_pslverr"}, 32'(up_pslverr), 32'(isErr));
                if (clrAtEnd) err_clr = 1'b1;
            end
        end
        if (!done) checkOutput({tag, "_complete"}, 32'(up_pready), 32'd1);

        up_psel    = 1'b0;
        up_penable = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;

        if (clrAtEnd) modelClear();
        if (isErr) begin
            mCnt   = (mCnt < 255) ? mCnt + 1 : 255;
            mAddr  = addr;
            mCause = cause;
            if (cause == 3) mQuar[idx] = 1'b1;
        end
        checkLog(tag);
    endtask

    initial begin
        rst        = 1'b1;
        up_paddr   = '0;
        up_pwdata  = '0;
        up_pwrite  = 1'b0;
        up_psel    = 1'b0;
        up_penable = 1'b0;
        err_clr    = 1'b0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            slaveData[i] = 8'h10 + 8'(i);
            slaveWait[i] = 0;
        end
        modelClear();

        repeat (3) @(negedge clk);
        checkOutput("rst_psel",    32'(s_psel),     32'd0);
        checkOutput("rst_penable", 32'(s_penable),  32'd0);
        checkOutput("rst_pready",  32'(up_pready),  32'd0);
        checkOutput("rst_pslverr", 32'(up_pslverr), 32'd0);
        checkLog("rst");
        rst = 1'b0;

        slaveData[1] = 8'h5A;
        applyStimulus("zero_wait", 16'h0103, 1'b0, 8'h00, 1'b0);

        slaveWait[2] = 3;
        applyStimulus("wait3", 16'h0207, 1'b1, 8'hC3, 1'b0);
        slaveWait[2] = 0;

        applyStimulus("unmapped", 16'h0700, 1'b0, 8'h00, 1'b0);

`ifdef APB_FABRIC_TIMEOUT_EN
        slaveWait[3] = 1000;
        applyStimulus("timeout", 16'h0305, 1'b0, 8'h00, 1'b0);
        applyStimulus("quarantined", 16'h0300, 1'b0, 8'h00, 1'b0);
        pulseClear();
        slaveWait[3] = 0;
        slaveData[3] = 8'hA7;
        applyStimulus("unquarantined", 16'h0300, 1'b0, 8'h00, 1'b0);
        slaveWait[0] = TIMEOUT - 1;
        applyStimulus("just_in_time", 16'h0011, 1'b1, 8'h66, 1'b0);
        slaveWait[0] = 0;
`endif

        applyStimulus("pre_collision", 16'h0800, 1'b0, 8'h00, 1'b0);
        applyStimulus("collision", 16'h0900, 1'b0, 8'h00, 1'b1);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < SLAVE_CNT; i++) begin
                slaveData[i] = 8'($urandom);
                slaveWait[i] = int'($urandom_range(0, 6));
            end
            applyStimulus("random", {8'($urandom_range(0, 6)), 8'($urandom)},
                          1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        for (int t = 0; t < 260; t++) begin
            applyStimulus("saturate", {8'($urandom_range(4, 255)), 8'($urandom)}, 1'b0, 8'h00, 1'b0);
        end

        slaveWait[0] = 2;
        @(negedge clk);
        up_psel    = 1'b1;
        up_penable = 1'b0;
        up_paddr   = 16'h0001;
        @(negedge clk);
        up_penable = 1'b1;
        @(negedge clk);
        checkOutput("mid_t1_pready", 32'(up_pready), 32'd0);
        @(negedge clk);
        checkOutput("mid_t2_psel", 32'(s_psel), 32'b0001);
        rst = 1'b1;
        #1;
        checkOutput("rst_hi_psel",    32'(s_psel),     32'd0);
        checkOutput("rst_hi_penable", 32'(s_penable),  32'd0);
        checkOutput("rst_hi_pready",  32'(up_pready),  32'd0);
        checkOutput("rst_hi_pslverr", 32'(up_pslverr), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        up_psel    = 1'b0;
        up_penable = 1'b0;
        #1;
        modelClear();
        checkOutput("post_rst_psel",    32'(s_psel),    32'd0);
        checkOutput("post_rst_penable", 32'(s_penable), 32'd0);
        checkOutput("post_rst_pready",  32'(up_pready), 32'd0);
        checkLog("post_rst");
        slaveWait[0] = 0;
        slaveData[0] = 8'h3E;
        applyStimulus("after_reset", 16'h0042, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
